// File: rtl/sec_ded_dec_pipe.sv
`timescale 1ns/1ps
// sec_ded_dec_pipe
//    Pipelined Hsiao SEC-DED decoder for the memory read path. Sits between
//    RAM read data and its consumer.
//
//    Stage 1 registers the codeword, the correction mode and the syndrome.
//    Stage 2 registers the error classification and the corrected codeword.
//    Stages hand off with valid/ready backpressure.
//
//    Ports
//       CLK, RST_N       clock (rising edge), asynchronous active-low reset
//       IN_VLD / IN_RDY  input handshake
//       IN               codeword: [DATA_W-1:0] data, upper PAR_W bits check
//       CORR_EN          1 = correct single errors, 0 = detect only
//                        (sampled together with the input word)
//       OUT_VLD/OUT_RDY  output handshake
//       FINOUT, DOUT     (corrected) codeword and its data field
//       SYN, ERR, SGL, DBL  syndrome and classification of the output word
//       CNT_CLR          synchronous clear of the counters and the log
//       SGL_CNT, DBL_CNT saturating counts of delivered SGL / DBL words
//       LOG_VLD, LOG_SYN sticky syndrome of the first delivered ERR word
module sec_ded_dec_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PAR_W  = 7,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      IN_VLD,
   output logic                      IN_RDY,
   input  logic [DATA_W+PAR_W-1:0]   IN,
   input  logic                      CORR_EN,
   output logic                      OUT_VLD,
   input  logic                      OUT_RDY,
   output logic [DATA_W+PAR_W-1:0]   FINOUT,
   output logic [DATA_W-1:0]         DOUT,
   output logic [PAR_W-1:0]          SYN,
   output logic                      ERR,
   output logic                      SGL,
   output logic                      DBL,
   input  logic                      CNT_CLR,
   output logic [CNT_W-1:0]          SGL_CNT,
   output logic [CNT_W-1:0]          DBL_CNT,
   output logic                      LOG_VLD,
   output logic [PAR_W-1:0]          LOG_SYN
);

   localparam int unsigned CW   = DATA_W + PAR_W;
   localparam int unsigned NVAL = 1 << PAR_W;

   typedef logic [CW-1:0][PAR_W-1:0] hmat_t;

   // Number of odd-weight (>= 3) PAR_W-bit values available as data columns.
   function automatic int unsigned avail_cols();
      int unsigned n;
      int          w;
      n = 0;
      for (int unsigned v = 0; v < NVAL; v++) begin
         w = $countones(PAR_W'(v));
         if (w >= 3 && (w % 2) == 1) n++;
      end
      return n;
   endfunction

   // H matrix columns: data bits take the odd-weight (>= 3) values in
   // ascending order, check bit j takes the unit vector 1<<j.
   function automatic hmat_t gen_cols();
      hmat_t          h;
      int unsigned    n;
      int             w;
      logic [PAR_W-1:0] c;
      h = '0;
      n = 0;
      for (int unsigned v = 0; v < NVAL; v++) begin
         c = PAR_W'(v);
         w = $countones(c);
         if (w >= 3 && (w % 2) == 1 && n < DATA_W) begin
            h[n] = c;
            n++;
         end
      end
      for (int unsigned j = 0; j < PAR_W; j++) h[DATA_W+j] = PAR_W'(1) << j;
      return h;
   endfunction

   localparam hmat_t COLS = gen_cols();

   if (avail_cols() < DATA_W) begin : g_par_w_too_small
      $error("sec_ded_dec_pipe: PAR_W too small for DATA_W");
   end

   // ---------------- handshake ----------------
   logic v1, v2;
   logic rdy1, rdy2;

   assign rdy2   = ~v2 | OUT_RDY;
   assign rdy1   = ~v1 | rdy2;
   assign IN_RDY = rdy1;

   // ---------------- stage 1: syndrome ----------------
   logic [PAR_W-1:0] syn_c;

   // Check columns are unit vectors, so the check field seeds the XOR and
   // only the data columns need folding in.
   always_comb begin
      syn_c = IN[CW-1:DATA_W];
      for (int unsigned i = 0; i < DATA_W; i++) begin
         if (IN[i]) syn_c = syn_c ^ COLS[i];
      end
   end

   logic [CW-1:0]    w1;
   logic             c1;
   logic [PAR_W-1:0] s1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         v1 <= 1'b0;
         w1 <= '0;
         c1 <= 1'b0;
         s1 <= '0;
      end else if (rdy1) begin
         v1 <= IN_VLD;
         if (IN_VLD) begin
            w1 <= IN;
            c1 <= CORR_EN;
            s1 <= syn_c;
         end
      end
   end

   // ---------------- stage 2: classify and correct ----------------
   logic [CW-1:0] flip_c;
   logic [CW-1:0] fin_c;
   logic          err_c, sgl_c, dbl_c;

   // All columns are distinct and nonzero, so at most one flip bit is set
   // and a zero syndrome never matches.
   always_comb begin
      flip_c = '0;
      for (int unsigned b = 0; b < CW; b++) begin
         flip_c[b] = (s1 == COLS[b]);
      end
      err_c = |s1;
      sgl_c = |flip_c;
      dbl_c = err_c & ~sgl_c;
      fin_c = (c1 & sgl_c) ? (w1 ^ flip_c) : w1;
   end

   logic [CW-1:0]    fin2;
   logic [PAR_W-1:0] syn2;
   logic             err2, sgl2, dbl2;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         v2   <= 1'b0;
         fin2 <= '0;
         syn2 <= '0;
         err2 <= 1'b0;
         sgl2 <= 1'b0;
         dbl2 <= 1'b0;
      end else if (rdy2) begin
         v2 <= v1;
         if (v1) begin
            fin2 <= fin_c;
            syn2 <= s1;
            err2 <= err_c;
            sgl2 <= sgl_c;
            dbl2 <= dbl_c;
         end
      end
   end

   assign OUT_VLD = v2;
   assign FINOUT  = fin2;
   assign DOUT    = fin2[DATA_W-1:0];
   assign SYN     = syn2;
   assign ERR     = err2;
   assign SGL     = sgl2;
   assign DBL     = dbl2;

   // ---------------- error statistics ----------------
   logic             deliver;
   logic [CNT_W-1:0] sgl_cnt, dbl_cnt;
   logic             log_vld;
   logic [PAR_W-1:0] log_syn;

   assign deliver = v2 & OUT_RDY;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sgl_cnt <= '0;
         dbl_cnt <= '0;
         log_vld <= 1'b0;
         log_syn <= '0;
      end else if (CNT_CLR) begin
         sgl_cnt <= '0;
         dbl_cnt <= '0;
         log_vld <= 1'b0;
         log_syn <= '0;
      end else if (deliver) begin
         if (sgl2 && sgl_cnt != '1) sgl_cnt <= sgl_cnt + 1'b1;
         if (dbl2 && dbl_cnt != '1) dbl_cnt <= dbl_cnt + 1'b1;
         if (err2 && !log_vld) begin
            log_vld <= 1'b1;
            log_syn <= syn2;
         end
      end
   end

   assign SGL_CNT = sgl_cnt;
   assign DBL_CNT = dbl_cnt;
   assign LOG_VLD = log_vld;
   assign LOG_SYN = log_syn;

endmodule

// File: tb/tb_sec_ded_dec_pipe.sv
`timescale 1ns/1ps
// tb_sec_ded_dec_pipe
//    Directed and randomized checks of sec_ded_dec_pipe against a queue
//    based reference model. A second instance with CNT_W = 2 shares the
//    stimulus to exercise counter saturation.
module tb_sec_ded_dec_pipe;

   localparam int unsigned DW = 32;
   localparam int unsigned PW = 7;
   localparam int unsigned CW = DW + PW;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          IN_VLD = 1'b0;
   logic          CORR_EN = 1'b0;
   logic          OUT_RDY = 1'b0;
   logic          CNT_CLR = 1'b0;
   logic [CW-1:0] IN = '0;

   logic          IN_RDY, OUT_VLD, ERR, SGL, DBL, LOG_VLD;
   logic [CW-1:0] FINOUT;
   logic [DW-1:0] DOUT;
   logic [PW-1:0] SYN, LOG_SYN;
   logic [15:0]   SGL_CNT, DBL_CNT;

   logic          b_IN_RDY, b_OUT_VLD, b_ERR, b_SGL, b_DBL, b_LOG_VLD;
   logic [CW-1:0] b_FINOUT;
   logic [DW-1:0] b_DOUT;
   logic [PW-1:0] b_SYN, b_LOG_SYN;
   logic [1:0]    b_SGL_CNT, b_DBL_CNT;

   always #5 CLK = ~CLK;

   sec_ded_dec_pipe #(.DATA_W(DW), .PAR_W(PW), .CNT_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .IN(IN),
      .CORR_EN(CORR_EN), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY),
      .FINOUT(FINOUT), .DOUT(DOUT), .SYN(SYN), .ERR(ERR), .SGL(SGL),
      .DBL(DBL), .CNT_CLR(CNT_CLR), .SGL_CNT(SGL_CNT), .DBL_CNT(DBL_CNT),
      .LOG_VLD(LOG_VLD), .LOG_SYN(LOG_SYN)
   );

   sec_ded_dec_pipe #(.DATA_W(DW), .PAR_W(PW), .CNT_W(2)) dut_sat (
      .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_RDY(b_IN_RDY), .IN(IN),
      .CORR_EN(CORR_EN), .OUT_VLD(b_OUT_VLD), .OUT_RDY(OUT_RDY),
      .FINOUT(b_FINOUT), .DOUT(b_DOUT), .SYN(b_SYN), .ERR(b_ERR),
      .SGL(b_SGL), .DBL(b_DBL), .CNT_CLR(CNT_CLR), .SGL_CNT(b_SGL_CNT),
      .DBL_CNT(b_DBL_CNT), .LOG_VLD(b_LOG_VLD), .LOG_SYN(b_LOG_SYN)
   );

   typedef struct {
      logic [CW-1:0] fin;
      logic [PW-1:0] syn;
      logic          err;
      logic          sgl;
      logic          dbl;
   } exp_t;

   exp_t          q[$];
   logic [PW-1:0] col [CW];
   int            checks = 0;
   int            failures = 0;
   int unsigned   sgl_m, dbl_m, sgl2_m, delivered;
   logic          log_v_m;
   logic [PW-1:0] log_s_m;
   logic          last_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // H matrix from its definition: unit vectors for check bits, odd-weight
   // (>= 3) values in ascending order for data bits.
   task automatic build_cols();
      int unsigned n = 0;
      for (int unsigned v = 0; v < 128; v++) begin
         if (n < DW && $countones(v) >= 3 && ($countones(v) % 2) == 1) begin
            col[n] = PW'(v);
            n++;
         end
      end
      for (int unsigned j = 0; j < PW; j++) col[DW+j] = PW'(1 << j);
   endtask

   function automatic logic [PW-1:0] syn_of(input logic [CW-1:0] w);
      logic [PW-1:0] s = '0;
      for (int unsigned b = 0; b < CW; b++) if (w[b]) s ^= col[b];
      return s;
   endfunction

   function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
      logic [PW-1:0] c = '0;
      for (int unsigned i = 0; i < DW; i++) if (d[i]) c ^= col[i];
      return {c, d};
   endfunction

   function automatic exp_t model(input logic [CW-1:0] w, input logic corr);
      exp_t e;
      e.syn = syn_of(w);
      e.err = (e.syn != '0);
      e.sgl = 1'b0;
      e.fin = w;
      for (int unsigned b = 0; b < CW; b++) begin
         if (e.err && col[b] == e.syn) begin
            e.sgl = 1'b1;
            if (corr) e.fin[b] = ~w[b];
         end
      end
      e.dbl = e.err && !e.sgl;
      return e;
   endfunction

   task automatic zero_model();
      sgl_m = 0; dbl_m = 0; sgl2_m = 0; log_v_m = 1'b0; log_s_m = '0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One cycle of the model-checked engine: drive, check outputs against the
   // queue head, account accept/deliver, advance, check statistics.
   task automatic step(input logic vld, input logic [CW-1:0] w, input logic corr,
                       input logic ordy, input logic clr, output logic acc);
      logic exp_rdy;
      exp_t e;
      IN_VLD = vld; IN = w; CORR_EN = corr; OUT_RDY = ordy; CNT_CLR = clr;
      #1;
      exp_rdy = (q.size() < 2) || ordy;
      last_rdy = IN_RDY;
      chk("in_rdy", IN_RDY, exp_rdy);
      if (q.size() == 0) chk("out_vld_idle", OUT_VLD, 0);
      else if (OUT_VLD) begin
         e = q[0];
         chk("finout", FINOUT, e.fin);
         chk("dout", DOUT, e.fin[DW-1:0]);
         chk("syn", SYN, e.syn);
         chk("flags", {ERR, SGL, DBL}, {e.err, e.sgl, e.dbl});
         if (ordy) begin
            void'(q.pop_front());
            delivered++;
            if (!clr) begin
               if (e.sgl && sgl_m < 65535) sgl_m++;
               if (e.sgl && sgl2_m < 3) sgl2_m++;
               if (e.dbl && dbl_m < 65535) dbl_m++;
               if (e.err && !log_v_m) begin log_v_m = 1'b1; log_s_m = e.syn; end
            end
         end
      end
      if (clr) zero_model();
      acc = vld && exp_rdy;
      if (acc) q.push_back(model(w, corr));
      tick();
      chk("sgl_cnt", SGL_CNT, sgl_m);
      chk("dbl_cnt", DBL_CNT, dbl_m);
      chk("sgl_cnt_sat", b_SGL_CNT, sgl2_m);
      chk("log", {LOG_VLD, LOG_SYN}, {log_v_m, log_s_m});
   endtask

   // Directed single word: visible outputs after return, OUT_RDY held high.
   task automatic send1(input logic [CW-1:0] w, input logic corr);
      IN = w; IN_VLD = 1'b1; CORR_EN = corr; OUT_RDY = 1'b1;
      tick();
      IN_VLD = 1'b0; CORR_EN = ~corr; IN = '0;
      tick();
   endtask

   function automatic logic [CW-1:0] rand_word();
      logic [CW-1:0] w;
      int unsigned   b1, b2;
      w = encode($urandom);
      b1 = $urandom_range(0, CW-1);
      b2 = (b1 + 1 + $urandom_range(0, CW-2)) % CW;
      case ($urandom_range(0, 3))
         1: w[b1] = ~w[b1];
         2: begin w[b1] = ~w[b1]; w[b2] = ~w[b2]; end
         3: w = {$urandom, $urandom};
         default: ;
      endcase
      return w;
   endfunction

   localparam logic [CW-1:0] W_CLEAN1 = {7'b0000111, 32'h1};
   localparam logic [CW-1:0] W_CLEAN2 = {7'b0001100, 32'h3};
   localparam logic [CW-1:0] W_SGL_D  = {7'b0000111, 32'h0};
   localparam logic [CW-1:0] W_SGL_C  = {7'b0000110, 32'h1};
   localparam logic [CW-1:0] W_DBL    = {7'b0000111, 32'h2};
   localparam logic [CW-1:0] W_ALL1   = {7'b1111111, 32'h0};

   initial begin
      logic          acc;
      logic          saw_low;
      logic [CW-1:0] bpw [4];
      int unsigned   idx;

      build_cols();
      zero_model();
      delivered = 0;

      // reset state
      tick(); tick();
      chk("rst_out_vld", OUT_VLD, 0);
      chk("rst_finout", FINOUT, 0);
      chk("rst_syn_flags", {SYN, ERR, SGL, DBL}, 0);
      chk("rst_cnts", {SGL_CNT, DBL_CNT, LOG_VLD, LOG_SYN}, 0);
      RST_N = 1'b1;

      // clean words back-to-back, latency 2
      IN_VLD = 1'b1; IN = W_CLEAN1; OUT_RDY = 1'b1; CORR_EN = 1'b1;
      #1 chk("first_accept_rdy", IN_RDY, 1);
      tick();
      chk("lat_not_1", OUT_VLD, 0);
      IN = W_CLEAN2;
      tick();
      chk("clean1_vld", OUT_VLD, 1);
      chk("clean1_fin", FINOUT, W_CLEAN1);
      chk("clean1_flags", {SYN, ERR, SGL, DBL}, 0);
      IN_VLD = 1'b0;
      tick();
      chk("clean2_vld", OUT_VLD, 1);
      chk("clean2_fin", FINOUT, W_CLEAN2);
      chk("clean2_flags", {SYN, ERR, SGL, DBL}, 0);
      tick();
      chk("clean_drained", OUT_VLD, 0);
      chk("clean_cnts", {SGL_CNT, DBL_CNT, LOG_VLD}, 0);

      // single data error, corrected
      send1(W_SGL_D, 1'b1);
      chk("sgl_d_syn", SYN, 7'b0000111);
      chk("sgl_d_flags", {ERR, SGL, DBL}, 3'b110);
      chk("sgl_d_fin", FINOUT, W_CLEAN1);
      chk("sgl_d_dout", DOUT, 32'h1);
      tick();
      chk("sgl_d_cnt", SGL_CNT, 1);
      chk("sgl_d_log", {LOG_VLD, LOG_SYN}, {1'b1, 7'b0000111});

      // same word, detect only
      send1(W_SGL_D, 1'b0);
      chk("det_flags", {ERR, SGL, DBL}, 3'b110);
      chk("det_fin", FINOUT, W_SGL_D);
      tick();
      chk("det_cnt", SGL_CNT, 2);

      // check-bit error
      send1(W_SGL_C, 1'b1);
      chk("sgl_c_syn", SYN, 7'b0000001);
      chk("sgl_c_sgl", SGL, 1);
      chk("sgl_c_chk", FINOUT[CW-1:DW], 7'b0000111);
      tick();

      // double error
      send1(W_DBL, 1'b1);
      chk("dbl_syn", SYN, 7'b0001100);
      chk("dbl_flags", {ERR, SGL, DBL}, 3'b101);
      chk("dbl_fin", FINOUT, W_DBL);
      tick();
      chk("dbl_cnt", DBL_CNT, 1);

      // unmatched odd syndrome
      send1(W_ALL1, 1'b1);
      chk("ones_syn", SYN, 7'b1111111);
      chk("ones_flags", {ERR, SGL, DBL}, 3'b101);
      chk("ones_fin", FINOUT, W_ALL1);
      tick();

      // two more SGL words: five in total
      send1(W_SGL_D, 1'b1); tick();
      send1(W_SGL_D, 1'b1); tick();
      chk("sgl_cnt5", SGL_CNT, 5);
      chk("sgl_sat3", b_SGL_CNT, 3);
      chk("dbl_cnt2", {DBL_CNT, b_DBL_CNT}, {16'd2, 2'd2});
      chk("log_first", {LOG_VLD, LOG_SYN}, {1'b1, 7'b0000111});

      // clear coincident with a delivered SGL word
      send1(W_SGL_C, 1'b1);
      chk("clr_deliver_vld", OUT_VLD, 1);
      CNT_CLR = 1'b1;
      tick();
      CNT_CLR = 1'b0;
      chk("clr_cnts", {SGL_CNT, DBL_CNT, b_SGL_CNT}, 0);
      chk("clr_log", {LOG_VLD, LOG_SYN}, 0);

      RST_N = 1'b0;
      tick(); tick();
      RST_N = 1'b1;
      zero_model();

      // backpressure: 4 words, OUT_RDY low for cycles 3..6
      for (int i = 0; i < 4; i++) bpw[i] = rand_word();
      idx = 0; saw_low = 1'b0; delivered = 0;
      for (int c = 0; c < 16; c++) begin
         step(idx < 4, (idx < 4) ? bpw[idx] : '0, 1'b1, !(c >= 3 && c <= 6), 1'b0, acc);
         if (!last_rdy) saw_low = 1'b1;
         if (acc) idx++;
      end
      chk("bp_in_rdy_dropped", saw_low, 1);
      chk("bp_accepted", idx, 4);
      chk("bp_delivered", delivered, 4);

      // randomized traffic with a mid-stream reset
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, acc);
         if (c == 200) begin
            #1 RST_N = 1'b0;
            #1;
            chk("midrst_out_vld", OUT_VLD, 0);
            chk("midrst_cnts", {SGL_CNT, DBL_CNT, LOG_VLD, b_SGL_CNT}, 0);
            q.delete();
            zero_model();
            tick();
            RST_N = 1'b1;
         end
      end

      for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
      chk("drain_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
